// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128/AES-256 key-expansion sequencer: steps a shared one-round key
// datapath and streams each round key into the round-key store.
module aes_key_sched_ctrl #(
    parameter int RK_LAT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic [1:0]   i_mode,
    input  logic [127:0] i_key_lo,
    input  logic [127:0] i_key_hi,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err,
    output logic [3:0]   o_rk_rd,
    output logic [1:0]   o_rk_mode,
    output logic [127:0] o_rk_prev_key,
    output logic [127:0] o_rk_current_key,
    input  logic [127:0] i_rk_round_key,
    output logic         o_wr_en,
    output logic [3:0]   o_wr_addr,
    output logic [127:0] o_wr_data
);

    localparam int         LW       = (RK_LAT < 1) ? 1 : $clog2(RK_LAT + 1);
    localparam logic [1:0] MODE_128 = 2'b00;
    localparam logic [1:0] MODE_256 = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD0,
        S_LOAD1,
        S_CALC,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [3:0]     r_step;
    logic [LW-1:0]  r_lat;
    logic           r_busy;
    logic           r_done;
    logic           r_err;
    logic [1:0]     r_mode;
    logic [127:0]   r_prev;
    logic [127:0]   r_cur;
    logic           r_wr_en;
    logic [3:0]     r_wr_addr;
    logic [127:0]   r_wr_data;

    logic           w_last_round;
    logic           w_step_final;

    assign w_last_round = (r_mode == MODE_256) ? (r_step == 4'd14) : (r_step == 4'd10);
    // The datapath result is only trusted on the last cycle of the hold window.
    assign w_step_final = (r_lat == LW'(RK_LAT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_step    <= 4'd0;
            r_lat     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_mode    <= 2'b00;
            r_prev    <= '0;
            r_cur     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 4'd0;
            r_wr_data <= '0;
        end else begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_wr_en <= 1'b0;
            if (r_state != S_IDLE && i_abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_lat   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_busy <= 1'b0;
                        if (!i_abort && i_start) begin
                            if (i_mode == MODE_128 || i_mode == MODE_256) begin
                                r_mode  <= i_mode;
                                r_busy  <= 1'b1;
                                r_state <= S_LOAD0;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    S_LOAD0: begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= 4'd0;
                        r_wr_data <= i_key_lo;
                        if (r_mode == MODE_256) begin
                            r_state <= S_LOAD1;
                        end else begin
                            r_prev  <= i_key_lo;
                            r_cur   <= i_key_lo;
                            r_step  <= 4'd1;
                            r_lat   <= '0;
                            r_state <= S_CALC;
                        end
                    end
                    S_LOAD1: begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= 4'd1;
                        r_wr_data <= i_key_hi;
                        r_prev    <= i_key_lo;
                        r_cur     <= i_key_hi;
                        r_step    <= 4'd2;
                        r_lat     <= '0;
                        r_state   <= S_CALC;
                    end
                    S_CALC: begin
                        if (w_step_final) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_step;
                            r_wr_data <= i_rk_round_key;
                            r_lat     <= '0;
                            if (w_last_round) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_step <= r_step + 4'd1;
                                // AES-256 needs the key two rounds back; AES-128 only the last one.
                                if (r_mode == MODE_256) begin
                                    r_prev <= r_cur;
                                end else begin
                                    r_prev <= i_rk_round_key;
                                end
                                r_cur <= i_rk_round_key;
                            end
                        end else begin
                            r_lat <= r_lat + LW'(1);
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_err            = r_err;
    assign o_rk_rd          = r_step;
    assign o_rk_mode        = r_mode;
    assign o_rk_prev_key    = r_prev;
    assign o_rk_current_key = r_cur;
    assign o_wr_en          = r_wr_en;
    assign o_wr_addr        = r_wr_addr;
    assign o_wr_data        = r_wr_data;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench: two sequencers (RK_LAT 0 and 2) each driving a behavioural AES
// round-key datapath, results checked against FIPS-197 round keys.
module tb_aes_key_sched_ctrl;

    localparam logic [127:0] K128    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K128_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K128_R5 = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    localparam logic [127:0] K128_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K256_LO = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] K256_HI = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K256_R2 = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] K256_RE = 128'hfe4890d1e6188d0b046df344706c631e;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start_a, abort_a, start_b, abort_b;
    logic [1:0]   mode;
    logic [127:0] key_lo, key_hi;

    logic         busy_a, done_a, err_a, wr_en_a;
    logic [3:0]   rk_rd_a, wr_addr_a;
    logic [1:0]   rk_mode_a;
    logic [127:0] prev_a, cur_a, rk_a, wr_data_a;

    logic         busy_b, done_b, err_b, wr_en_b;
    logic [3:0]   rk_rd_b, wr_addr_b;
    logic [1:0]   rk_mode_b;
    logic [127:0] prev_b, cur_b, rk_b, wr_data_b, pipe_b0, pipe_b1;

    // ---------------- behavioural one-round key datapath ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r, base;
        r    = 8'h01;
        base = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gmul(r, base);
            base = gmul(base, base);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 1; i < n; i++) r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
        return r;
    endfunction

    function automatic logic [127:0] aes_next(input logic [3:0] rd, input logic [1:0] m,
                                              input logic [127:0] prev, input logic [127:0] cur);
        logic [31:0]  t, n0, n1, n2, n3;
        logic [127:0] base;
        if (m == 2'b10) begin
            if (!rd[0]) t = subword({cur[23:0], cur[31:24]}) ^ {rcon(int'(rd) >> 1), 24'h0};
            else        t = subword(cur[31:0]);
            base = prev;
        end else begin
            t    = subword({cur[23:0], cur[31:24]}) ^ {rcon(int'(rd)), 24'h0};
            base = cur;
        end
        n0 = base[127:96] ^ t;
        n1 = base[95:64]  ^ n0;
        n2 = base[63:32]  ^ n1;
        n3 = base[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    assign rk_a = aes_next(rk_rd_a, rk_mode_a, prev_a, cur_a);
    always @(posedge clk) begin
        pipe_b0 <= aes_next(rk_rd_b, rk_mode_b, prev_b, cur_b);
        pipe_b1 <= pipe_b0;
    end
    assign rk_b = pipe_b1;

    aes_key_sched_ctrl #(.RK_LAT(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_start(start_a), .i_abort(abort_a), .i_mode(mode),
        .i_key_lo(key_lo), .i_key_hi(key_hi), .o_busy(busy_a), .o_done(done_a), .o_err(err_a),
        .o_rk_rd(rk_rd_a), .o_rk_mode(rk_mode_a), .o_rk_prev_key(prev_a),
        .o_rk_current_key(cur_a), .i_rk_round_key(rk_a), .o_wr_en(wr_en_a),
        .o_wr_addr(wr_addr_a), .o_wr_data(wr_data_a)
    );

    aes_key_sched_ctrl #(.RK_LAT(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_start(start_b), .i_abort(abort_b), .i_mode(mode),
        .i_key_lo(key_lo), .i_key_hi(key_hi), .o_busy(busy_b), .o_done(done_b), .o_err(err_b),
        .o_rk_rd(rk_rd_b), .o_rk_mode(rk_mode_b), .o_rk_prev_key(prev_b),
        .o_rk_current_key(cur_b), .i_rk_round_key(rk_b), .o_wr_en(wr_en_b),
        .o_wr_addr(wr_addr_b), .o_wr_data(wr_data_b)
    );

    // ---------------- key-store scoreboards ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] store_a [16];
    logic [127:0] store_b [16];
    logic [15:0]  rd_mask_a = 16'h0;
    int hold_b [16] = '{default: 0};
    int wcnt_a = 0, done_cnt_a = 0, err_cnt_a = 0, done_at_a = 0, start_cyc_a = 0;
    int wcnt_b = 0, done_cnt_b = 0, done_at_b = 0, start_cyc_b = 0;

    always @(negedge clk) begin
        if (wr_en_a) begin
            store_a[wr_addr_a] <= wr_data_a;
            wcnt_a <= wcnt_a + 1;
        end
        if (done_a) begin
            done_cnt_a <= done_cnt_a + 1;
            done_at_a  <= cyc - start_cyc_a;
        end
        if (err_a) err_cnt_a <= err_cnt_a + 1;
        if (busy_a) rd_mask_a[rk_rd_a] <= 1'b1;
        if (wr_en_b) begin
            store_b[wr_addr_b] <= wr_data_b;
            wcnt_b <= wcnt_b + 1;
        end
        if (done_b) begin
            done_cnt_b <= done_cnt_b + 1;
            done_at_b  <= cyc - start_cyc_b;
        end
        if (busy_b) hold_b[rk_rd_b] <= hold_b[rk_rd_b] + 1;
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0, n_pass = 0, n_fail = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start_a(input logic [1:0] m);
        mode        = m;
        start_a     = 1'b1;
        start_cyc_a = cyc;
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int base);
        for (int i = 0; i < 100 && done_cnt_a == base; i++) tick();
    endtask

    int wbase, dbase, ebase, wsnap;

    initial begin
        rst_n = 1'b0; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        mode = 2'b00; key_lo = '0; key_hi = '0;
        repeat (3) tick();
        check("rst_ctrl_a", 128'({busy_a, done_a, err_a, wr_en_a, wr_addr_a, rk_rd_a, rk_mode_a}), 128'h0);
        check("rst_wr_data_a", wr_data_a, 128'h0);
        check("rst_prev_a", prev_a, 128'h0);
        check("rst_cur_a", cur_a, 128'h0);
        check("rst_ctrl_b", 128'({busy_b, done_b, err_b, wr_en_b, wr_addr_b, rk_rd_b, rk_mode_b}), 128'h0);
        rst_n = 1'b1;
        tick();

        // AES-256 full expansion
        key_lo = K256_LO; key_hi = K256_HI;
        dbase = done_cnt_a; wbase = wcnt_a;
        pulse_start_a(2'b10);
        wait_done_a(dbase);
        check_int("a256_done_pulses", done_cnt_a - dbase, 1);
        check_int("a256_done_cycle", done_at_a, 16);
        repeat (3) tick();
        check_int("a256_writes", wcnt_a - wbase, 15);
        check("a256_addr0", store_a[0], K256_LO);
        check("a256_addr1", store_a[1], K256_HI);
        check("a256_addr2", store_a[2], K256_R2);
        check("a256_addr14", store_a[14], K256_RE);
        check_int("a256_rd_steps", int'(rd_mask_a & 16'hFFFE), 32'h7FFC);
        check("a256_idle_busy", 128'(busy_a), 128'h0);

        // AES-128 full expansion; mode input changes after start must not matter
        key_lo = K128; key_hi = '0;
        dbase = done_cnt_a; wbase = wcnt_a; ebase = err_cnt_a;
        pulse_start_a(2'b00);
        mode = 2'b11;
        wait_done_a(dbase);
        check_int("a128_done_cycle", done_at_a, 12);
        repeat (3) tick();
        check_int("a128_writes", wcnt_a - wbase, 11);
        check("a128_addr0", store_a[0], K128);
        check("a128_addr1", store_a[1], K128_R1);
        check("a128_addr10", store_a[10], K128_RA);
        check("a128_rk_mode", 128'(rk_mode_a), 128'h0);
        check_int("a128_no_err", err_cnt_a - ebase, 0);

        // unsupported mode
        ebase = err_cnt_a; wbase = wcnt_a;
        mode = 2'b01; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("err_pulse", 128'(err_a), 128'h1);
        check("err_busy", 128'(busy_a), 128'h0);
        tick();
        check("err_one_cycle", 128'(err_a), 128'h0);
        repeat (3) tick();
        check_int("err_count", err_cnt_a - ebase, 1);
        check_int("err_no_writes", wcnt_a - wbase, 0);

        // abort at rk_rd=5, then a clean rerun
        key_lo = K128;
        dbase = done_cnt_a;
        pulse_start_a(2'b00);
        for (int i = 0; i < 50 && rk_rd_a != 4'd5; i++) tick();
        check_int("abort_reach_rd5", int'(rk_rd_a), 5);
        wsnap = wcnt_a;
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("abort_busy", 128'(busy_a), 128'h0);
        check("abort_wr_en", 128'(wr_en_a), 128'h0);
        repeat (20) tick();
        check_int("abort_no_writes", wcnt_a - wsnap, 0);
        check_int("abort_no_done", done_cnt_a - dbase, 0);
        dbase = done_cnt_a; wbase = wcnt_a;
        pulse_start_a(2'b00);
        wait_done_a(dbase);
        check_int("rerun_done_cycle", done_at_a, 12);
        repeat (3) tick();
        check_int("rerun_writes", wcnt_a - wbase, 11);
        check("rerun_addr5", store_a[5], K128_R5);
        check("rerun_addr10", store_a[10], K128_RA);

        // start re-pulsed mid-run is ignored
        dbase = done_cnt_a; wbase = wcnt_a;
        pulse_start_a(2'b00);
        repeat (4) tick();
        mode = 2'b10; start_a = 1'b1;
        tick();
        start_a = 1'b0; mode = 2'b00;
        wait_done_a(dbase);
        check_int("repulse_done_cycle", done_at_a, 12);
        repeat (5) tick();
        check_int("repulse_writes", wcnt_a - wbase, 11);
        check_int("repulse_single_done", done_cnt_a - dbase, 1);
        check("repulse_rk_mode", 128'(rk_mode_a), 128'h0);
        check("repulse_addr10", store_a[10], K128_RA);

        // synchronous reset mid-run
        key_lo = K256_LO; key_hi = K256_HI;
        dbase = done_cnt_a;
        pulse_start_a(2'b10);
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        check("midrst_ctrl", 128'({busy_a, done_a, err_a, wr_en_a, wr_addr_a, rk_rd_a, rk_mode_a}), 128'h0);
        check("midrst_wr_data", wr_data_a, 128'h0);
        check("midrst_prev", prev_a, 128'h0);
        check("midrst_cur", cur_a, 128'h0);
        rst_n = 1'b1;
        repeat (20) tick();
        check_int("midrst_no_done", done_cnt_a - dbase, 0);
        check("midrst_idle", 128'(busy_a), 128'h0);

        // RK_LAT=2 instance, AES-128
        key_lo = K128; key_hi = '0; mode = 2'b00;
        start_b = 1'b1; start_cyc_b = cyc;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 200 && done_cnt_b == 0; i++) tick();
        check_int("lat2_done_cycle", done_at_b, 32);
        repeat (3) tick();
        check_int("lat2_writes", wcnt_b, 11);
        check_int("lat2_hold_rd1", hold_b[1], 3);
        check_int("lat2_hold_rd5", hold_b[5], 3);
        check_int("lat2_hold_rd9", hold_b[9], 3);
        check("lat2_addr1", store_b[1], K128_R1);
        check("lat2_addr10", store_b[10], K128_RA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
